// File: rtl/btn_cond_pkg.sv
// Shared constants and helpers for the button event conditioner.
// Holds the default sizes and the lowest-set-index priority helper.
package btn_cond_pkg;

  localparam int NBTN_DEF        = 8;
  localparam int IDX_W_DEF       = 3;
  localparam int DEB_1MS_AT_1MHZ = 1000;

  // Widest mask the priority helper accepts
  localparam int MASK_MAX   = 32;
  localparam int MASK_IDX_W = 5;

  function automatic logic [MASK_IDX_W-1:0] lowest_set_idx(input logic [MASK_MAX-1:0] mask);
    logic [MASK_IDX_W-1:0] idx;
    idx = {MASK_IDX_W{1'b0}};
    // Scan downward so the lowest set bit is the last one written
    for (int i = MASK_MAX - 1; i >= 0; i--) begin
      if (mask[i]) begin
        idx = MASK_IDX_W'(i);
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/btn_event_conditioner_debounce.sv
// One button bit: 2-FF synchroniser, stability counter and accepted level.
// rise/fall strobe in the cycle before level changes, so a registered copy lines up with level.
module btn_debounce_bit
  import btn_cond_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_1MS_AT_1MHZ
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam int CNT_W = $clog2(DEB_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  logic             sync1_r;
  logic             sync2_r;
  logic             level_r;
  logic [CNT_W-1:0] cnt_r;
  logic             flip_s;

  // A differing input that has now been stable long enough is accepted this cycle
  always_comb begin
    flip_s = 1'b0;
    if ((sync2_r != level_r) && (cnt_r == CNT_LAST)) begin
      flip_s = 1'b1;
    end else begin
      flip_s = 1'b0;
    end
  end

  // Synchroniser chain, stability counter and debounced level
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
      cnt_r   <= {CNT_W{1'b0}};
      level_r <= 1'b0;
    end else begin
      sync1_r <= raw;
      sync2_r <= sync1_r;
      if (sync2_r == level_r) begin
        cnt_r <= {CNT_W{1'b0}};
      end else if (flip_s) begin
        cnt_r   <= {CNT_W{1'b0}};
        level_r <= sync2_r;
      end else begin
        cnt_r <= cnt_r + CNT_W'(1);
      end
    end
  end

  assign level = level_r;
  assign rise  = flip_s & sync2_r;
  assign fall  = flip_s & ~sync2_r;

endmodule

// File: rtl/btn_event_conditioner.sv
// Debounces NBTN buttons and queues presses as indexed events on a valid/ready port.
// Define BTN_RELEASE_EVT_EN to also queue debounced releases (reported with evt_rel=1).
module btn_event_conditioner
  import btn_cond_pkg::*;
#(
  parameter int NBTN       = NBTN_DEF,
  parameter int DEB_CYCLES = DEB_1MS_AT_1MHZ,
  localparam int IDX_W     = $clog2(NBTN)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic [NBTN-1:0]  btn_raw,
  output logic [NBTN-1:0]  btn_level,
  output logic [NBTN-1:0]  btn_press,
  output logic             evt_valid,
  output logic [IDX_W-1:0] evt_idx,
  input  logic             evt_ready,
  output logic             evt_rel,
  output logic             evt_overflow
);

  localparam logic [NBTN-1:0] ONE_HOT0 = {{(NBTN-1){1'b0}}, 1'b1};

  logic [NBTN-1:0]  rise_s;
  logic [NBTN-1:0]  fall_s;
  logic [NBTN-1:0]  press_r;
  logic [NBTN-1:0]  pend_r;
  logic [NBTN-1:0]  pend_clr_s;
  logic             ovf_r;
  logic             ovf_hit_s;
  logic             evt_valid_s;
  logic [IDX_W-1:0] evt_idx_s;

  for (genvar g = 0; g < NBTN; g++) begin : g_bit
    btn_debounce_bit #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
      .clk   (clk),
      .rst   (rst),
      .raw   (btn_raw[g]),
      .level (btn_level[g]),
      .rise  (rise_s[g]),
      .fall  (fall_s[g])
    );
  end

`ifdef BTN_RELEASE_EVT_EN
  logic [NBTN-1:0] relp_r;
  logic [NBTN-1:0] rel_pend_r;
  logic [NBTN-1:0] rel_clr_s;
  logic            evt_rel_s;

  // Presses always win over releases; only the chosen mask loses its bit on accept
  always_comb begin
    evt_valid_s = (|pend_r) | (|rel_pend_r);
    evt_rel_s   = 1'b0;
    evt_idx_s   = {IDX_W{1'b0}};
    pend_clr_s  = {NBTN{1'b0}};
    rel_clr_s   = {NBTN{1'b0}};
    if (|pend_r) begin
      evt_idx_s = IDX_W'(lowest_set_idx(MASK_MAX'(pend_r)));
      evt_rel_s = 1'b0;
    end else begin
      evt_idx_s = IDX_W'(lowest_set_idx(MASK_MAX'(rel_pend_r)));
      evt_rel_s = |rel_pend_r;
    end
    if (evt_valid_s && evt_ready && !evt_rel_s) begin
      pend_clr_s = ONE_HOT0 << evt_idx_s;
    end else if (evt_valid_s && evt_ready) begin
      rel_clr_s = ONE_HOT0 << evt_idx_s;
    end else begin
      pend_clr_s = {NBTN{1'b0}};
      rel_clr_s  = {NBTN{1'b0}};
    end
    ovf_hit_s = (|(press_r & pend_r & ~pend_clr_s)) | (|(relp_r & rel_pend_r & ~rel_clr_s));
  end

  // Release pulses and release mask
  always_ff @(posedge clk) begin
    if (rst) begin
      relp_r     <= {NBTN{1'b0}};
      rel_pend_r <= {NBTN{1'b0}};
    end else begin
      relp_r     <= fall_s & {NBTN{ena}};
      rel_pend_r <= (rel_pend_r & ~rel_clr_s) | relp_r;
    end
  end

  assign evt_rel = evt_rel_s;
`else
  logic unused_fall_s;

  // Lowest pending press is offered; it leaves the mask once the consumer takes it
  always_comb begin
    evt_valid_s = |pend_r;
    evt_idx_s   = IDX_W'(lowest_set_idx(MASK_MAX'(pend_r)));
    pend_clr_s  = {NBTN{1'b0}};
    if (evt_valid_s && evt_ready) begin
      pend_clr_s = ONE_HOT0 << evt_idx_s;
    end else begin
      pend_clr_s = {NBTN{1'b0}};
    end
    ovf_hit_s = |(press_r & pend_r & ~pend_clr_s);
  end

  assign unused_fall_s = ^fall_s;
  assign evt_rel       = 1'b0;
`endif

  // Press pulses, pending press mask and sticky overflow flag
  always_ff @(posedge clk) begin
    if (rst) begin
      press_r <= {NBTN{1'b0}};
      pend_r  <= {NBTN{1'b0}};
      ovf_r   <= 1'b0;
    end else begin
      press_r <= rise_s & {NBTN{ena}};
      pend_r  <= (pend_r & ~pend_clr_s) | press_r;
      ovf_r   <= ovf_r | ovf_hit_s;
    end
  end

  assign btn_press    = press_r;
  assign evt_valid    = evt_valid_s;
  assign evt_idx      = evt_idx_s;
  assign evt_overflow = ovf_r;

endmodule

// File: tb/tb_btn_event_conditioner.sv
// Bench for btn_event_conditioner (DEB_CYCLES=4, default build without release events).
module tb_btn_event_conditioner;

  localparam int NBTN = 8;
  localparam int DEB  = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       ena;
  logic       evt_ready;
  logic [7:0] btn_raw;
  logic [7:0] btn_level;
  logic [7:0] btn_press;
  logic       evt_valid;
  logic [2:0] evt_idx;
  logic       evt_rel;
  logic       evt_overflow;

  btn_event_conditioner #(.NBTN(NBTN), .DEB_CYCLES(DEB)) dut (
    .clk          (clk),
    .rst          (rst),
    .ena          (ena),
    .btn_raw      (btn_raw),
    .btn_level    (btn_level),
    .btn_press    (btn_press),
    .evt_valid    (evt_valid),
    .evt_idx      (evt_idx),
    .evt_ready    (evt_ready),
    .evt_rel      (evt_rel),
    .evt_overflow (evt_overflow)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: raw sample history, accepted levels, press pulses, pending set
  logic [7:0] hist [0:DEB];
  logic [7:0] m_level;
  logic [7:0] m_press;
  logic [7:0] m_pend;
  logic       m_ovf;

  typedef struct {
    logic       rst;
    logic       ena;
    logic [7:0] raw;
    logic       rdy;
    logic [7:0] level;
    logic [7:0] press;
    logic       valid;
    logic [2:0] idx;
    logic       ovf;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [2:0] ref_lowest(input logic [7:0] m);
    logic [2:0] r;
    logic       found;
    r = 3'd0;
    found = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (m[i] && !found) begin
        r = 3'(i);
        found = 1'b1;
      end
    end
    return r;
  endfunction

  // A level flips once the last DEB synchronised samples all disagree with it
  task automatic model_step();
    logic [7:0] nl;
    logic       opp;
    logic       taken;
    logic       v;
    logic [2:0] id;
    if (rst) begin
      for (int k = 0; k <= DEB; k++) hist[k] = 8'h00;
      m_level = 8'h00;
      m_press = 8'h00;
      m_pend  = 8'h00;
      m_ovf   = 1'b0;
    end else begin
      v  = |m_pend;
      id = ref_lowest(m_pend);
      nl = m_level;
      for (int b = 0; b < 8; b++) begin
        opp = 1'b1;
        for (int k = 1; k <= DEB; k++) begin
          if (hist[k][b] == m_level[b]) opp = 1'b0;
        end
        if (opp) nl[b] = ~m_level[b];
      end
      for (int b = 0; b < 8; b++) begin
        taken = v && evt_ready && (id == 3'(b));
        if (m_press[b]) begin
          if (m_pend[b] && !taken) m_ovf = 1'b1;
          m_pend[b] = 1'b1;
        end else if (taken) begin
          m_pend[b] = 1'b0;
        end
      end
      m_press = nl & ~m_level & {8{ena}};
      m_level = nl;
      for (int k = DEB; k >= 1; k--) hist[k] = hist[k-1];
      hist[0] = btn_raw;
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    chk("mdl_level", btn_level, m_level);
    chk("mdl_press", btn_press, m_press);
    chk("mdl_valid", 8'(evt_valid), 8'(|m_pend));
    chk("mdl_idx", 8'(evt_idx), 8'(ref_lowest(m_pend)));
    chk("mdl_rel", 8'(evt_rel), 8'h00);
    chk("mdl_ovf", 8'(evt_overflow), 8'(m_ovf));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic add(input logic r, input logic e, input logic [7:0] raw, input logic rdy,
                     input logic [7:0] lvl, input logic [7:0] prs, input logic vld,
                     input logic [2:0] idx, input logic ovf);
    vec_t v;
    v.rst = r; v.ena = e; v.raw = raw; v.rdy = rdy;
    v.level = lvl; v.press = prs; v.valid = vld; v.idx = idx; v.ovf = ovf;
    vecs.push_back(v);
  endtask

  initial begin
    rst = 1'b1; ena = 1'b0; evt_ready = 1'b0; btn_raw = 8'h00;

    // Reset with all buttons held, then release: levels appear 6 edges later
    repeat (2) add(1'b1, 1'b0, 8'hFF, 1'b0, 8'h00, 8'h00, 1'b0, 3'd0, 1'b0);
    repeat (5) add(1'b0, 1'b0, 8'hFF, 1'b0, 8'h00, 8'h00, 1'b0, 3'd0, 1'b0);
    add(1'b0, 1'b0, 8'hFF, 1'b0, 8'hFF, 8'h00, 1'b0, 3'd0, 1'b0);
    repeat (5) add(1'b0, 1'b0, 8'h00, 1'b0, 8'hFF, 8'h00, 1'b0, 3'd0, 1'b0);
    add(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0, 3'd0, 1'b0);
    // Button 3 press, held event, accept
    repeat (5) add(1'b0, 1'b1, 8'h08, 1'b0, 8'h00, 8'h00, 1'b0, 3'd0, 1'b0);
    add(1'b0, 1'b1, 8'h08, 1'b0, 8'h08, 8'h08, 1'b0, 3'd0, 1'b0);
    repeat (3) add(1'b0, 1'b1, 8'h08, 1'b0, 8'h08, 8'h00, 1'b1, 3'd3, 1'b0);
    add(1'b0, 1'b1, 8'h08, 1'b1, 8'h08, 8'h00, 1'b0, 3'd0, 1'b0);
    // Button 5 bounce of 3 cycles is rejected
    repeat (3) add(1'b0, 1'b1, 8'h28, 1'b0, 8'h08, 8'h00, 1'b0, 3'd0, 1'b0);
    repeat (5) add(1'b0, 1'b1, 8'h08, 1'b0, 8'h08, 8'h00, 1'b0, 3'd0, 1'b0);

    for (int i = 0; i < vecs.size(); i++) begin
      rst = vecs[i].rst; ena = vecs[i].ena; btn_raw = vecs[i].raw; evt_ready = vecs[i].rdy;
      cyc();
      chk($sformatf("tbl%0d_level", i), btn_level, vecs[i].level);
      chk($sformatf("tbl%0d_press", i), btn_press, vecs[i].press);
      chk($sformatf("tbl%0d_valid", i), 8'(evt_valid), 8'(vecs[i].valid));
      chk($sformatf("tbl%0d_idx", i), 8'(evt_idx), 8'(vecs[i].idx));
      chk($sformatf("tbl%0d_ovf", i), 8'(evt_overflow), 8'(vecs[i].ovf));
    end

    // Buttons 1 and 6 together: lowest index first, one per cycle
    btn_raw = 8'h4A; evt_ready = 1'b1;
    run(5);
    chk("t4_level_pre", btn_level, 8'h08);
    cyc();
    chk("t4_level", btn_level, 8'h4A);
    chk("t4_press", btn_press, 8'h42);
    cyc();
    chk("t4_valid1", 8'(evt_valid), 8'h01);
    chk("t4_idx1", 8'(evt_idx), 8'h01);
    cyc();
    chk("t4_valid6", 8'(evt_valid), 8'h01);
    chk("t4_idx6", 8'(evt_idx), 8'h06);
    cyc();
    chk("t4_empty", 8'(evt_valid), 8'h00);

    // Press/release/press button 2 without acceptance -> overflow
    evt_ready = 1'b0; btn_raw = 8'h4E;
    run(5);
    cyc();
    chk("t5_press", btn_press, 8'h04);
    cyc();
    chk("t5_idx", 8'(evt_idx), 8'h02);
    chk("t5_ovf0", 8'(evt_overflow), 8'h00);
    btn_raw = 8'h4A;
    run(6);
    chk("t5_rel_level", btn_level, 8'h4A);
    chk("t5_rel_valid", 8'(evt_valid), 8'h01);
    btn_raw = 8'h4E;
    run(6);
    chk("t5_press2", btn_press, 8'h04);
    chk("t5_ovf_pre", 8'(evt_overflow), 8'h00);
    cyc();
    chk("t5_ovf1", 8'(evt_overflow), 8'h01);
    chk("t5_idx2", 8'(evt_idx), 8'h02);
    evt_ready = 1'b1;
    cyc();
    chk("t5_one_event", 8'(evt_valid), 8'h00);
    evt_ready = 1'b0;
    run(3);
    chk("t5_ovf_sticky", 8'(evt_overflow), 8'h01);

    // Button 4 pressed while disabled: level follows, no pulse, no event
    btn_raw = 8'h4A;
    run(6);
    chk("t6_level_pre", btn_level, 8'h4A);
    ena = 1'b0; btn_raw = 8'h5A;
    for (int i = 0; i < 6; i++) begin
      cyc();
      chk("t6_no_press", btn_press, 8'h00);
    end
    chk("t6_level", btn_level, 8'h5A);
    cyc();
    chk("t6_no_event", 8'(evt_valid), 8'h00);
    chk("t6_rel", 8'(evt_rel), 8'h00);
    ena = 1'b1;

    // Reset with an event pending discards it
    btn_raw = 8'h5B;
    run(7);
    chk("rst_pend_valid", 8'(evt_valid), 8'h01);
    chk("rst_pend_idx", 8'(evt_idx), 8'h00);
    rst = 1'b1;
    cyc();
    chk("rst_valid", 8'(evt_valid), 8'h00);
    chk("rst_ovf", 8'(evt_overflow), 8'h00);
    chk("rst_level", btn_level, 8'h00);
    chk("rst_press", btn_press, 8'h00);

    // Random bouncing buttons against the reference model
    for (int n = 0; n < 3000; n++) begin
      rst = (n < 1) || ($urandom_range(0, 299) == 0);
      ena = ($urandom_range(0, 9) != 0);
      evt_ready = ($urandom_range(0, 2) == 0);
      for (int b = 0; b < 8; b++) begin
        if ($urandom_range(0, 5) == 0) btn_raw[b] = ~btn_raw[b];
      end
      cyc();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
